// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and parameter defaults for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        PEND  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int STAGES_DEF       = 6;
    localparam int NSRC_DEF         = 4;
    localparam int REFETCH_HOLD_DEF = 2;
    localparam int CNT_W_DEF        = 32;
    localparam int HOLD_W           = 4;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Request/response bundle between the pipeline stages and the controller.
interface pipeline_ctrl_if #(
    parameter int STAGES = 6,
    parameter int NSRC   = 4
);
    logic [NSRC-1:0]   stall_req;
    logic [STAGES-1:0] hazard_req;
    logic [STAGES-1:0] br_req;
    logic              dslot_younger;
    logic              exc_flush;
    logic              mem_refetch;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] flush;
    logic              br_ack;

    modport master (
        output stall_req, hazard_req, br_req, dslot_younger, exc_flush, mem_refetch,
        input  stall, flush, br_ack
    );

    modport slave (
        input  stall_req, hazard_req, br_req, dslot_younger, exc_flush, mem_refetch,
        output stall, flush, br_ack
    );
endinterface

// File: rtl/pipeline_ctrl_hz_enc.sv
// Highest-set-bit encoder with a valid flag; used for hazard and branch stage indices.
module pipeline_ctrl_hz_enc #(
    parameter int W  = 6,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req_i,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    // Scan upward so the highest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = 0; i < W; i++) begin
            idx_o = req_i[i] ? IW'(i) : idx_o;
            vld_o = vld_o | req_i[i];
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: global stalls, exception/refetch flush FSM,
// per-stage hazard bubbles, branch mispredict flush and saturating perf counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int STAGES       = STAGES_DEF,
    parameter int NSRC         = NSRC_DEF,
    parameter int REFETCH_HOLD = REFETCH_HOLD_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    pipeline_ctrl_if.slave     pif,
    input  logic               perf_clr,
    output logic [1:0]         state_o,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam int                IW       = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [STAGES-1:0] ALL_ONES = {STAGES{1'b1}};
    localparam logic [STAGES-1:0] STAGE0   = STAGES'(1);
    localparam logic [HOLD_W-1:0] HOLD_LD  = HOLD_W'(REFETCH_HOLD);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    logic                g_s, e_s, flush_ev_s;
    logic [IW-1:0]       hz_idx_s, br_idx_s;
    logic                hz_vld_s, br_vld_s, br_blk_s;
    logic [STAGES-1:0]   stall_s, flush_s, stall_out_s;
    logic                br_ack_s, stall_hit_s;

    pipeline_ctrl_hz_enc #(.W(STAGES), .IW(IW)) u_hz_enc (
        .req_i (pif.hazard_req),
        .idx_o (hz_idx_s),
        .vld_o (hz_vld_s)
    );

    pipeline_ctrl_hz_enc #(.W(STAGES), .IW(IW)) u_br_enc (
        .req_i (pif.br_req),
        .idx_o (br_idx_s),
        .vld_o (br_vld_s)
    );

    assign g_s      = |pif.stall_req;
    assign e_s      = pif.exc_flush | pif.mem_refetch;
    // A branch is deferred while its own stage is held by a hazard bubble.
    assign br_blk_s = hz_vld_s && (br_idx_s <= hz_idx_s);

    // Next-state, hold counter and zero-latency stall/flush decode.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        stall_s    = '0;
        flush_s    = '0;
        br_ack_s   = 1'b0;
        flush_ev_s = 1'b0;
        case (state_q)
            RUN: begin
                if (e_s && !g_s) begin
                    flush_ev_s = 1'b1;
                    count_d    = HOLD_LD;
                    state_d    = DRAIN;
                end else if (g_s) begin
                    stall_s = ALL_ONES;
                    state_d = e_s ? PEND : HOLD;
                end else begin
                    for (int i = 0; i < STAGES; i++) begin
                        stall_s[i] = hz_vld_s && (i <= int'(hz_idx_s));
                        flush_s[i] = (hz_vld_s && (i == int'(hz_idx_s) + 1)) ||
                                     (br_vld_s && !br_blk_s &&
                                      (pif.dslot_younger ? (i + 1 < int'(br_idx_s))
                                                         : (i < int'(br_idx_s))));
                    end
                    br_ack_s = br_vld_s && !br_blk_s;
                end
            end
            HOLD: begin
                stall_s = ALL_ONES;
                if (e_s) begin
                    state_d = PEND;
                end else if (!g_s) begin
                    state_d = RUN;
                end else begin
                    state_d = HOLD;
                end
            end
            PEND: begin
                if (g_s) begin
                    stall_s = ALL_ONES;
                end else begin
                    flush_ev_s = 1'b1;
                    count_d    = HOLD_LD;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (e_s && !g_s) begin
                    flush_ev_s = 1'b1;
                    count_d    = HOLD_LD;
                end else if (e_s) begin
                    stall_s = ALL_ONES;
                    state_d = PEND;
                end else if (g_s) begin
                    stall_s = ALL_ONES;
                end else begin
                    stall_s = STAGE0;
                    count_d = count_q - HOLD_W'(1);
                    state_d = (count_q <= HOLD_W'(1)) ? RUN : DRAIN;
                end
            end
            default: begin
                state_d = RUN;
                count_d = '0;
            end
        endcase
        if (flush_ev_s) begin
            flush_s = ALL_ONES;
        end else begin
            flush_s = flush_s;
        end
    end

    assign stall_out_s = stall_s & ~flush_s;
    assign stall_hit_s = stall_out_s[STAGES-1] | g_s;

    // Saturating performance counters; clear wins over a same-cycle increment.
    always_comb begin
        if (perf_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            stall_cnt_d = (stall_hit_s && stall_cnt_q != CNT_MAX) ? stall_cnt_q + CNT_W'(1)
                                                                   : stall_cnt_q;
            flush_cnt_d = (flush_ev_s && flush_cnt_q != CNT_MAX) ? flush_cnt_q + CNT_W'(1)
                                                                  : flush_cnt_q;
        end
    end

    // State, hold counter and perf counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= RUN;
            count_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pif.stall  = stall_out_s;
    assign pif.flush  = flush_s;
    assign pif.br_ack = br_ack_s;
    assign state_o    = state_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl with a queue-based scoreboard and negedge monitor.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    logic       clk;
    logic       resetn;
    logic       perf_clr;
    logic [1:0] state_o;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;

    int total = 0;
    int bad   = 0;
    int step_id = 0;

    typedef struct packed {
        int         id;
        logic [5:0] st;
        logic [5:0] fl;
        logic       ack;
        logic [1:0] state;
        logic       chk;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t exp_q[$];

    pipeline_ctrl_if #(.STAGES(6), .NSRC(4)) pif ();

    pipeline_ctrl #(.STAGES(6), .NSRC(4), .REFETCH_HOLD(2), .CNT_W(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .pif       (pif),
        .perf_clr  (perf_clr),
        .state_o   (state_o),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input logic rn, input logic [3:0] sr, input logic [5:0] hz,
                        input logic [5:0] br, input logic ds, input logic ex,
                        input logic rf, input logic pc,
                        input logic [5:0] e_st, input logic [5:0] e_fl, input logic e_ack,
                        input logic [1:0] e_state, input logic chk,
                        input logic [3:0] e_sc, input logic [3:0] e_fc);
        exp_t e;
        @(posedge clk);
        #1;
        resetn            = rn;
        pif.stall_req     = sr;
        pif.hazard_req    = hz;
        pif.br_req        = br;
        pif.dslot_younger = ds;
        pif.exc_flush     = ex;
        pif.mem_refetch   = rf;
        perf_clr          = pc;
        step_id++;
        e = '{id: step_id, st: e_st, fl: e_fl, ack: e_ack, state: e_state,
              chk: chk, sc: e_sc, fc: e_fc};
        exp_q.push_back(e);
    endtask

    // Monitor: pop one expectation per cycle and compare away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (pif.stall !== e.st) begin
                bad++;
                $display("FAIL step%0d stall got=%b exp=%b", e.id, pif.stall, e.st);
            end
            total++;
            if (pif.flush !== e.fl) begin
                bad++;
                $display("FAIL step%0d flush got=%b exp=%b", e.id, pif.flush, e.fl);
            end
            total++;
            if (pif.br_ack !== e.ack) begin
                bad++;
                $display("FAIL step%0d br_ack got=%b exp=%b", e.id, pif.br_ack, e.ack);
            end
            total++;
            if (state_o !== e.state) begin
                bad++;
                $display("FAIL step%0d state got=%0d exp=%0d", e.id, state_o, e.state);
            end
            if (e.chk) begin
                total++;
                if (stall_cnt !== e.sc) begin
                    bad++;
                    $display("FAIL step%0d stall_cnt got=%0d exp=%0d", e.id, stall_cnt, e.sc);
                end
                total++;
                if (flush_cnt !== e.fc) begin
                    bad++;
                    $display("FAIL step%0d flush_cnt got=%0d exp=%0d", e.id, flush_cnt, e.fc);
                end
            end
        end
    end

    initial begin
        resetn = 1'b0;
        pif.stall_req = '0; pif.hazard_req = '0; pif.br_req = '0;
        pif.dslot_younger = 1'b0; pif.exc_flush = 1'b0; pif.mem_refetch = 1'b0;
        perf_clr = 1'b0;
        //   rn    sr       hz         br         ds    ex    rf    pc    stall      flush      ack   state  chk   sc     fc
        step(1'b0, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, RUN,   1'b1, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, RUN,   1'b1, 4'd0,  4'd0);
        // hazard bubbles
        step(1'b1, 4'b0000, 6'b000100, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000111, 6'b001000, 1'b0, RUN,   1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, RUN,   1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000011, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000011, 6'b000100, 1'b0, RUN,   1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b100001, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 6'b000000, 1'b0, RUN,   1'b0, 4'd0,  4'd0);
        // branch flushes
        step(1'b1, 4'b0000, 6'b000000, 6'b010000, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000111, 1'b1, RUN,   1'b1, 4'd1,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b010000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b001111, 1'b1, RUN,   1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b000001, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b1, RUN,   1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000010, 6'b001000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000111, 1'b1, RUN,   1'b0, 4'd0,  4'd0);
        // branch deferred behind a stage-5 hazard
        step(1'b1, 4'b0000, 6'b100000, 6'b010000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 6'b000000, 1'b0, RUN,   1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b100000, 6'b010000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 6'b000000, 1'b0, RUN,   1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b010000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b001111, 1'b1, RUN,   1'b1, 4'd3,  4'd0);
        // branch deferred by a global stall
        step(1'b1, 4'b0010, 6'b000000, 6'b000100, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 6'b000000, 1'b0, RUN,   1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b000100, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 6'b000000, 1'b0, HOLD,  1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b000100, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000011, 1'b1, RUN,   1'b1, 4'd5,  4'd0);
        // exception under a global stall: HOLD, PEND, flush, two DRAIN cycles
        step(1'b1, 4'b0001, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 6'b000000, 1'b0, RUN,   1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0001, 6'b000000, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 6'b111111, 6'b000000, 1'b0, HOLD,  1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0001, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 6'b000000, 1'b0, PEND,  1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0001, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 6'b000000, 1'b0, PEND,  1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0001, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 6'b000000, 1'b0, PEND,  1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b111111, 1'b0, PEND,  1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000001, 6'b000000, 1'b0, DRAIN, 1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000001, 6'b000000, 1'b0, DRAIN, 1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, RUN,   1'b1, 4'd10, 4'd1);
        // direct exception, refetch re-flush in DRAIN, freeze under G
        step(1'b1, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000000, 6'b111111, 1'b0, RUN,   1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000100, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000001, 6'b000000, 1'b0, DRAIN, 1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000000, 6'b111111, 1'b0, DRAIN, 1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000001, 6'b000000, 1'b0, DRAIN, 1'b1, 4'd10, 4'd3);
        step(1'b1, 4'b0100, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 6'b000000, 1'b0, DRAIN, 1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000001, 6'b000000, 1'b0, DRAIN, 1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, RUN,   1'b1, 4'd11, 4'd3);
        // stall counter saturation (4-bit)
        step(1'b1, 4'b1000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 6'b000000, 1'b0, RUN,   1'b0, 4'd0,  4'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b1000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 6'b000000, 1'b0, HOLD, 1'b0, 4'd0, 4'd0);
        end
        step(1'b1, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 6'b000000, 1'b0, HOLD,  1'b1, 4'd15, 4'd3);
        step(1'b1, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, RUN,   1'b1, 4'd15, 4'd3);
        // perf_clr wins over a same-cycle increment
        step(1'b1, 4'b0001, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 6'b111111, 6'b000000, 1'b0, RUN,   1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 6'b000000, 1'b0, HOLD,  1'b1, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, RUN,   1'b1, 4'd1,  4'd0);
        // reset mid-PEND discards the pending flush
        step(1'b1, 4'b0001, 6'b000000, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 6'b111111, 6'b000000, 1'b0, RUN,   1'b0, 4'd0,  4'd0);
        step(1'b1, 4'b0001, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 6'b000000, 1'b0, PEND,  1'b0, 4'd0,  4'd0);
        step(1'b0, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, RUN,   1'b1, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, RUN,   1'b1, 4'd0,  4'd0);
        step(1'b1, 4'b0000, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, RUN,   1'b1, 4'd0,  4'd0);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_queue left=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
